// File: rtl/alu_mdu_pkg.sv
// Shared opcode and state encodings for the ALU/MDU execute block.
package alu_mdu_pkg;

  // ADD..XOR keep their legacy encodings; the rest extend upward.
  typedef enum logic [4:0] {
    ADD    = 5'd0,
    SUB    = 5'd1,
    AND    = 5'd2,
    OR     = 5'd3,
    XOR    = 5'd4,
    SLL    = 5'd5,
    SRL    = 5'd6,
    SRA    = 5'd7,
    SLT    = 5'd8,
    SLTU   = 5'd9,
    MUL    = 5'd10,
    MULH   = 5'd11,
    MULHSU = 5'd12,
    MULHU  = 5'd13,
    DIV    = 5'd14,
    DIVU   = 5'd15,
    REM    = 5'd16,
    REMU   = 5'd17
  } e_aluOp;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } e_mduState;

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
module mdu_iter #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] ma,
  input  logic [WIDTH-1:0] mb,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic             busy, div_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc, lo_q, m;
  logic [WIDTH:0]   sum, msel, rsh, diff;
  logic             ge;

  // hi/lo are the values after this cycle's step, so the final step is visible
  // combinationally on the edge that completes the operation.
  always_comb begin
    sum  = {1'b0, acc} + {1'b0, m};
    msel = lo_q[0] ? sum : {1'b0, acc};
    rsh  = {acc, lo_q[WIDTH-1]};
    diff = rsh - {1'b0, m};
    ge   = !diff[WIDTH];
    if (div_q) begin
      hi = ge ? diff[WIDTH-1:0] : rsh[WIDTH-1:0];
      lo = {lo_q[WIDTH-2:0], ge};
    end else begin
      hi = msel[WIDTH:1];
      lo = {msel[0], lo_q[WIDTH-1:1]};
    end
  end

  assign done = busy && (cnt == '0);

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      busy  <= 1'b0;
      div_q <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      lo_q  <= '0;
      m     <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      div_q <= is_div;
      cnt   <= CNT_W'(WIDTH - 1);
      acc   <= '0;
      lo_q  <= ma;
      m     <= mb;
    end else if (busy) begin
      acc  <= hi;
      lo_q <= lo;
      cnt  <= cnt - 1'b1;
      if (cnt == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// RV32I register ALU plus RV32M multiply/divide with valid/ready on both sides.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [4:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_illegal
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  e_mduState        state, nxt;
  logic [4:0]       op_q;
  logic             neg_q, neg_r;
  logic             accept, a_sgn, b_sgn, sa, sb, b_zero, ovf, ill, it_done;
  logic [WIDTH-1:0] ma, mb, imm, it_hi, it_lo, it_res, quo, rem;
  logic [2*WIDTH-1:0] prod;
  logic [CNT_W-1:0] shamt;

  assign o_valid = (state == S_DONE);
  assign o_ready = (state == S_IDLE) || (o_valid && i_ready);
  assign accept  = i_valid && o_ready;

  // Operand signedness decides magnitudes and the sign fix-up after iteration.
  always_comb begin
    a_sgn = (i_op == MUL) || (i_op == MULH) || (i_op == MULHSU) ||
            (i_op == DIV) || (i_op == REM);
    b_sgn = (i_op == MUL) || (i_op == MULH) || (i_op == DIV) || (i_op == REM);
  end

  assign sa     = a_sgn && i_a[WIDTH-1];
  assign sb     = b_sgn && i_b[WIDTH-1];
  assign ma     = sa ? -i_a : i_a;
  assign mb     = sb ? -i_b : i_b;
  assign b_zero = (i_b == '0);
  assign ovf    = a_sgn && (i_a == MIN_VAL) && (i_b == '1);
  assign shamt  = i_b[CNT_W-1:0];

  always_comb begin
    imm = '0;
    nxt = S_DONE;
    ill = 1'b0;
    case (i_op)
      ADD:  imm = i_a + i_b;
      SUB:  imm = i_a - i_b;
      AND:  imm = i_a & i_b;
      OR:   imm = i_a | i_b;
      XOR:  imm = i_a ^ i_b;
      SLL:  imm = i_a << shamt;
      SRL:  imm = i_a >> shamt;
      SRA:  imm = $unsigned($signed(i_a) >>> shamt);
      SLT:  imm = {{(WIDTH-1){1'b0}}, $signed(i_a) < $signed(i_b)};
      SLTU: imm = {{(WIDTH-1){1'b0}}, i_a < i_b};
      MUL, MULH, MULHSU, MULHU: nxt = S_MUL;
      DIV, DIVU, REM, REMU: begin
        // Divide-by-zero and signed overflow resolve without iterating.
        if (b_zero)   imm = ((i_op == DIV) || (i_op == DIVU)) ? '1 : i_a;
        else if (ovf) imm = (i_op == DIV) ? MIN_VAL : '0;
        else          nxt = S_DIV;
      end
      default: ill = 1'b1;
    endcase
  end

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .gclk   (i_clk),
    .grst_n (i_rst_n),
    .start  (accept && (nxt != S_DONE)),
    .is_div (nxt == S_DIV),
    .ma     (ma),
    .mb     (mb),
    .done   (it_done),
    .hi     (it_hi),
    .lo     (it_lo)
  );

  always_comb begin
    prod = {it_hi, it_lo};
    if (neg_q) prod = -prod;
    quo = neg_q ? -it_lo : it_lo;
    rem = neg_r ? -it_hi : it_hi;
    it_res = rem;
    case (op_q)
      MUL:                 it_res = prod[WIDTH-1:0];
      MULH, MULHSU, MULHU: it_res = prod[2*WIDTH-1:WIDTH];
      DIV, DIVU:           it_res = quo;
      default:             it_res = rem;
    endcase
  end

  // Accept only happens in IDLE/DONE and it_done only in MUL/DIV, so the
  // branches never compete.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      o_result  <= '0;
      o_illegal <= 1'b0;
      op_q      <= 5'd0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else if (accept) begin
      state     <= nxt;
      o_result  <= imm;
      o_illegal <= ill;
      op_q      <= i_op;
      neg_q     <= sa ^ sb;
      neg_r     <= sa;
    end else if (it_done) begin
      state    <= S_DONE;
      o_result <= it_res;
    end else if (o_valid && i_ready) begin
      state <= S_IDLE;
    end
  end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised, handshaked successor to the single-cycle ALU.
- Executes all RV32I register-register ALU ops plus the RV32M multiply/divide ops.
- Simple ops complete in 1 cycle; MUL*/DIV*/REM* run iteratively over WIDTH cycles.
- Sits in the execute stage of the multi-cycle/pipelined core; valid/ready on both sides lets the core stall on long ops.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of 2 and at least 8.
- CNT_W, $clog2(WIDTH), width of the iteration counter; derived, not overridable.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  request valid.
- o_ready  output  1  block can accept a request this cycle.
- i_op  input  5  operation, type e_aluOp.
- i_a  input  WIDTH  operand A (rs1).
- i_b  input  WIDTH  operand B (rs2/imm).
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts the result.
- o_result  output  WIDTH  result.
- o_illegal  output  1  qualifies o_valid: op code not in e_aluOp.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE, o_valid=0, o_result=0, o_illegal=0, counter=0.
  - o_ready=1 once reset is released.
- States: IDLE, MUL, DIV, DONE.
- Accept: i_valid & o_ready at a rising edge (edge E0). Operands and op are latched at E0; inputs are ignored afterwards.
- o_ready = (state==IDLE) | (state==DONE & i_ready), so back-to-back issue is possible.
- Simple ops:
  - ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - Shift amount = i_b[CNT_W-1:0].
  - SLT is signed and SLTU unsigned; the result is zero-extended 0/1.
  - Arithmetic wraps modulo 2^WIDTH.
  - Path: IDLE -> DONE at E0; o_valid=1 for the cycle after E0 (latency 1).
- MUL, MULH, MULHSU, MULHU:
  - IDLE -> MUL at E0.
  - Shift-add over operand magnitudes, one bit per cycle, counter WIDTH-1 down to 0.
  - MUL -> DONE at edge E_WIDTH; o_valid rises after E_WIDTH (latency WIDTH+1 cycles).
  - Sign correction uses the latched operand signs.
  - MUL returns the low WIDTH bits; the H variants return the high WIDTH bits.
- DIV, DIVU, REM, REMU:
  - Restoring division on magnitudes, same timing as MUL.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- Special cases (latency 1, no iteration):
  - b==0: DIV/DIVU -> all ones; REM/REMU -> a.
  - Signed a==MIN, b==-1: DIV -> MIN; REM -> 0.
- Illegal op: IDLE -> DONE at E0, o_illegal=1, o_result=0.
- DONE:
  - o_valid=1; o_result and o_illegal stay stable until i_valid... more precisely, until i_ready=1 at an edge (backpressure holds indefinitely).
  - On i_ready & !i_valid: -> IDLE and o_valid=0.
  - On i_ready & i_valid: the new op is accepted in the same edge, so the next state is DONE/MUL/DIV as applicable.
- i_valid while busy (MUL/DIV): o_ready=0, so the request is not accepted; the requester holds it.
- Reset mid-operation:
  - Outputs return to reset values immediately, with no clock needed.
  - The partial result is discarded; the first op after release behaves normally.
- No X on any output under any legal or illegal input.

Decomposition:
- pa_riscv:
  - Extend with typedef enum logic [4:0] e_aluOp: existing ADD, SUB, AND, OR, XOR keep their values; add SLL, SRL, SRA, SLT, SLTU, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Add a local state enum for IDLE/MUL/DIV/DONE.
- Sub-module mdu_iter:
  - Contents: counter, accumulator/remainder, and the shift-add / restore-subtract datapath.
  - Parametrised by WIDTH.
  - Interface: start, is_div, magnitudes in; done, hi/lo (or quotient/remainder) out.
- Top level holds: handshake FSM, simple-op combinational datapath, sign fix-up, special-case detection.

Test Plan (WIDTH=32):
- ADD a=0x7FFFFFFF, b=1 -> 0x80000000, o_valid exactly 1 cycle after accept; SRA a=0x80000000, b=0x24 (shamt 4) -> 0xF8000000; SLTU a=1, b=0xFFFFFFFF -> 1.
- a=b=0xFFFFFFFF: MUL -> 0x00000001, MULHU -> 0xFFFFFFFE, MULH -> 0x00000000, MULHSU -> 0xFFFFFFFF; o_valid exactly 33 cycles after accept.
- DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; special cases have latency 1.
- Backpressure: i_ready=0 for 5 cycles after a DIVU result -> o_result/o_valid stable, o_ready=0. Then i_ready=1 with a new ADD presented -> ADD accepted on that edge, its result valid next cycle.
- Reset asserted at iteration 10 of DIV -> o_valid=0 at once, no spurious result after release. MUL 3*4 issued next -> 12 after 33 cycles.
- i_op=5'h1F -> o_valid with o_illegal=1, o_result=0, latency 1; next legal op clears o_illegal.
